// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM interface types: data word, RAM handshake state, arbiter state and request kind.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    IR = 2'd0,
    DR = 2'd1,
    DW = 2'd2
  } req_type_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin chooser: first set req bit after ptr, wrapping modulo CPUS.
// Purely combinational; the pointer register lives in the parent.
module rr_pick #(
  parameter int CPUS = 2,
  parameter int PW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   gnt_o,
  output logic            vld_o
);

  logic [PW-1:0] k;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    k     = '0;
    for (int i = 1; i <= CPUS; i++) begin
      k = PW'((int'(ptr_i) + i) % CPUS);
      if (!vld_o && req_i[k]) begin
        vld_o = 1'b1;
        gnt_o = k;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin RAM arbiter over CPUS cores (D over I within a core), registered grant and RAM drive.
// Grant appears the cycle after a request; wait drops in the first ACCESS cycle; watchdog aborts stalls.
module mem_arbiter_rr
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = $clog2(TIMEOUT)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     iload,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate,
  output logic                 timeout_err
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      state_q;
  logic [PW-1:0]   rr_q;
  logic [PW-1:0]   own_q;
  req_type_t       typ_q;
  word_t           addr_q;
  word_t           store_q;
  logic [CNTW-1:0] cnt_q;
  logic            terr_q;
  logic            ren_q;
  logic            wen_q;

  logic [CPUS-1:0] c_req;
  logic [PW-1:0]   pick;
  logic            pick_vld;
  logic            held;
  logic            done;
  logic            expired;

  assign c_req = iREN | dREN | dWEN;

  rr_pick #(.CPUS(CPUS), .PW(PW)) u_pick (
    .req_i (c_req),
    .ptr_i (rr_q),
    .gnt_o (pick),
    .vld_o (pick_vld)
  );

  // The owner must keep asserting the exact request that was latched.
  always_comb begin
    case (typ_q)
      DW:      held = dWEN[own_q];
      DR:      held = dREN[own_q];
      default: held = iREN[own_q];
    endcase
  end

  assign done    = (state_q == SERVE) && (ramstate == ACCESS);
  assign expired = (cnt_q == CNTW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= PW'(CPUS - 1);
      own_q   <= '0;
      typ_q   <= IR;
      addr_q  <= '0;
      store_q <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= SERVE;
            own_q   <= pick;
            cnt_q   <= '0;
            if (dWEN[pick]) begin
              typ_q   <= DW;
              addr_q  <= daddr[pick];
              store_q <= dstore[pick];
              wen_q   <= 1'b1;
              ren_q   <= 1'b0;
            end else if (dREN[pick]) begin
              typ_q   <= DR;
              addr_q  <= daddr[pick];
              store_q <= '0;
              wen_q   <= 1'b0;
              ren_q   <= 1'b1;
            end else begin
              typ_q   <= IR;
              addr_q  <= iaddr[pick];
              store_q <= '0;
              wen_q   <= 1'b0;
              ren_q   <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (done || !held || expired) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            // A dropped request leaves the pointer alone; completion and timeout advance it.
            if (done || held) rr_q <= own_q;
            if (!done && held) terr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    if (done) begin
      if (typ_q == IR) begin
        iwait[own_q] = 1'b0;
        iload[own_q] = ramload;
      end else begin
        dwait[own_q] = 1'b0;
        dload[own_q] = ramload;
      end
    end
  end

  assign ramREN      = ren_q;
  assign ramWEN      = wen_q;
  assign ramaddr     = addr_q;
  assign ramstore    = store_q;
  assign timeout_err = terr_q;

endmodule
